// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states, parity modes and baud default
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD = 2;
   localparam int DEFAULT_CLKS_PER_BIT = 5208;
endpackage

// File: rtl/lfsr_keystream.sv
// lfsr_keystream: Galois LFSR keystream register; load beats advance, zero seed becomes all-ones
module lfsr_keystream #(
   parameter int LFSR_W = 8,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hFF
) (
   input  logic              M_CLOCK,
   input  logic              M_RESET_N,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_value,
   input  logic              advance,
   output logic [LFSR_W-1:0] state
);
   logic [LFSR_W-1:0] state_q, state_d;
   always_comb
      state_d = load ? (load_value == '0 ? '1 : load_value)
              : advance ? {state_q[LFSR_W-2:0], 1'b0} ^ (state_q[LFSR_W-1] ? LFSR_TAPS : '0)
              : state_q;
   always_ff @(posedge M_CLOCK or negedge M_RESET_N)
      if (!M_RESET_N) state_q <= LFSR_SEED;
      else state_q <= state_d;
   assign state = state_q;
endmodule

// File: rtl/uart_lfsr_rx.sv
// uart_lfsr_rx: mid-bit sampling UART receiver with LFSR decrypt and valid/ready output
module uart_lfsr_rx import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_W = 8,
   parameter int PARITY_MODE = PARITY_NONE,
   parameter int STOP_BITS = 1,
   parameter int LFSR_W = 8,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hFF
) (
   input  logic              M_CLOCK,
   input  logic              M_RESET_N,
   input  logic              rx_in,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_value,
   input  logic              decrypt_en,
   output logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] raw_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W);
   logic              rx_meta_q, rx_s_q;
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              stop_q, stop_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [DATA_W-1:0] data_q, data_d, raw_q, raw_d;
   logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic              accept, tick;
   logic [LFSR_W-1:0] lfsr_state;
   lfsr_keystream #(.LFSR_W(LFSR_W), .LFSR_TAPS(LFSR_TAPS), .LFSR_SEED(LFSR_SEED)) u_lfsr (
      .M_CLOCK(M_CLOCK),
      .M_RESET_N(M_RESET_N),
      .load(seed_load),
      .load_value(seed_value),
      .advance(accept),
      .state(lfsr_state)
   );
   assign tick = cnt_q == '0;
   always_comb begin
      state_d = state_q;
      cnt_d = tick ? CW'(CLKS_PER_BIT - 1) : cnt_q - 1'b1;
      idx_d = idx_q;
      stop_d = stop_q;
      shift_d = shift_q;
      par_d = par_q;
      accept = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      case (state_q)
         IDLE: if (!rx_s_q) begin
            state_d = START;
            cnt_d = CW'(CLKS_PER_BIT / 2 - 1);
         end
         START: if (tick) begin
            state_d = rx_s_q ? IDLE : DATA;
            idx_d = '0;
            par_d = 1'b0;
         end
         DATA: if (tick) begin
            shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
            idx_d = idx_q + 1'b1;
            stop_d = 1'b0;
            if (idx_q == IW'(DATA_W - 1)) state_d = PARITY_MODE != PARITY_NONE ? PARITY : STOP;
         end
         PARITY: if (tick) begin
            par_d = (^shift_q ^ rx_s_q) != (PARITY_MODE == PARITY_ODD);
            state_d = STOP;
         end
         STOP: if (tick) begin
            if (!rx_s_q) begin
               ferr_d = 1'b1;
               state_d = WAIT_IDLE;
            end else if (stop_q == 1'(STOP_BITS - 1)) begin
               perr_d = par_q;
               accept = !par_q;
               state_d = IDLE;
            end else stop_d = 1'b1;
         end
         WAIT_IDLE: if (rx_s_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // key is taken before the advance lands, so a same-cycle seed load never affects this frame
   always_comb begin
      valid_d = accept | (valid_q & ~data_ready);
      ovr_d = accept & valid_q & ~data_ready;
      raw_d = accept ? shift_q : raw_q;
      data_d = accept ? (decrypt_en ? shift_q ^ lfsr_state[DATA_W-1:0] : shift_q) : data_q;
   end
   always_ff @(posedge M_CLOCK or negedge M_RESET_N)
      if (!M_RESET_N) begin
         rx_meta_q <= 1'b1;
         rx_s_q <= 1'b1;
         state_q <= IDLE;
         cnt_q <= '0;
         idx_q <= '0;
         stop_q <= 1'b0;
         shift_q <= '0;
         par_q <= 1'b0;
         data_q <= '0;
         raw_q <= '0;
         valid_q <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         rx_meta_q <= rx_in;
         rx_s_q <= rx_meta_q;
         state_q <= state_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         stop_q <= stop_d;
         shift_q <= shift_d;
         par_q <= par_d;
         data_q <= data_d;
         raw_q <= raw_d;
         valid_q <= valid_d;
         perr_q <= perr_d;
         ferr_q <= ferr_d;
         ovr_q <= ovr_d;
      end
   assign data_out = data_q;
   assign raw_out = raw_q;
   assign data_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err = ferr_q;
   assign overrun = ovr_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_lfsr_rx.sv
// tb_uart_lfsr_rx: directed frames against an 8N1 receiver and an even-parity receiver
module tb_uart_lfsr_rx;
   localparam int CPB = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   logic rx0 = 1'b1, rx1 = 1'b1, seed_load = 1'b0, ready0 = 1'b1;
   logic [7:0] seed_value = 8'h00;
   logic [7:0] dout0, raw0, dout1, raw1;
   logic valid0, perr0, ferr0, ovr0, busy0, valid1, perr1, ferr1, ovr1, busy1;
   int n_cmp = 0, n_err = 0, seed_hits = 0;
   int vc0 = 0, pc0 = 0, fc0 = 0, oc0 = 0, vc1 = 0, pc1 = 0;
   int vs, ps, fs, os;
   always #5 clk = ~clk;
   uart_lfsr_rx #(.CLKS_PER_BIT(CPB)) dut (
      .M_CLOCK(clk), .M_RESET_N(rst_n), .rx_in(rx0), .seed_load(seed_load), .seed_value(seed_value),
      .decrypt_en(1'b1), .data_out(dout0), .raw_out(raw0), .data_valid(valid0), .data_ready(ready0),
      .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0));
   uart_lfsr_rx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1)) dut_p (
      .M_CLOCK(clk), .M_RESET_N(rst_n), .rx_in(rx1), .seed_load(1'b0), .seed_value(8'h00),
      .decrypt_en(1'b1), .data_out(dout1), .raw_out(raw1), .data_valid(valid1), .data_ready(1'b1),
      .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1));
   always @(negedge clk) begin
      if (valid0) vc0++;
      if (perr0) pc0++;
      if (ferr0) fc0++;
      if (ovr0) oc0++;
      if (valid1) vc1++;
      if (perr1 | ferr1) pc1++;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input bit p, input logic b);
      if (p) rx1 = b; else rx0 = b;
      repeat (CPB) @(negedge clk);
   endtask
   task automatic send(input bit p, input logic [7:0] d, input int par, input logic stop, input bit seed_acc);
      drive(p, 1'b0);
      for (int i = 0; i < 8; i++) drive(p, d[i]);
      if (par >= 0) drive(p, par[0]);
      if (p) rx1 = stop; else rx0 = stop;
      for (int i = 0; i < CPB; i++) begin
         @(negedge clk);
         seed_load = seed_acc && dut.accept;
         if (seed_load) seed_hits++;
      end
      seed_load = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic snap();
      vs = vc0; ps = pc0; fs = fc0; os = oc0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst data_out", dout0, 8'h00);
      chk("rst raw_out", raw0, 8'h00);
      chk("rst valid", valid0, 1'b0);
      chk("rst pulses", {perr0, ferr0, ovr0}, 3'b000);
      chk("rst busy", busy0, 1'b0);
      chk("rst lfsr", dut.lfsr_state, 8'hFF);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      snap();
      send(0, 8'hA5, -1, 1'b1, 0);
      chk("a5 valid cycles", vc0 - vs, 1);
      chk("a5 raw", raw0, 8'hA5);
      chk("a5 data", dout0, 8'h5A);
      chk("a5 lfsr", dut.lfsr_state, 8'hE3);
      chk("a5 busy", busy0, 1'b0);
      send(0, 8'hE3, -1, 1'b1, 0);
      chk("e3 data", dout0, 8'h00);
      chk("e3 lfsr", dut.lfsr_state, 8'hDB);
      do_reset();
      snap();
      rx0 = 1'b0;
      repeat (5) @(negedge clk);
      rx0 = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch busy", busy0, 1'b0);
      chk("glitch valid", vc0 - vs, 0);
      chk("glitch pulses", (pc0 - ps) + (fc0 - fs), 0);
      chk("glitch lfsr", dut.lfsr_state, 8'hFF);
      snap();
      send(0, 8'h3C, -1, 1'b0, 0);
      repeat (16) @(negedge clk);
      chk("ferr pulse", fc0 - fs, 1);
      chk("ferr valid", vc0 - vs, 0);
      chk("ferr busy low line", busy0, 1'b1);
      rx0 = 1'b1;
      repeat (5) @(negedge clk);
      chk("ferr busy released", busy0, 1'b0);
      send(0, 8'hA5, -1, 1'b1, 0);
      chk("after ferr data", dout0, 8'h5A);
      do_reset();
      ready0 = 1'b0;
      send(0, 8'hA5, -1, 1'b1, 0);
      chk("ovr first valid", valid0, 1'b1);
      chk("ovr first data", dout0, 8'h5A);
      snap();
      send(0, 8'hE3, -1, 1'b1, 0);
      chk("ovr pulse", oc0 - os, 1);
      chk("ovr data", dout0, 8'h00);
      chk("ovr raw", raw0, 8'hE3);
      chk("ovr valid held", valid0, 1'b1);
      ready0 = 1'b1;
      repeat (2) @(negedge clk);
      chk("ovr valid drop", valid0, 1'b0);
      do_reset();
      send(0, 8'hA5, -1, 1'b1, 1);
      chk("seed hit accept", seed_hits, 1);
      chk("seed data", dout0, 8'h5A);
      chk("seed lfsr", dut.lfsr_state, 8'hFF);
      snap();
      drive(0, 1'b0);
      drive(0, 1'b1);
      drive(0, 1'b0);
      chk("mid busy", busy0, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid rst data", dout0, 8'h00);
      chk("mid rst raw", raw0, 8'h00);
      chk("mid rst busy", busy0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rx0 = 1'b1;
      repeat (200) @(negedge clk);
      chk("mid rst no valid", vc0 - vs, 0);
      chk("mid rst no pulses", (pc0 - ps) + (fc0 - fs) + (oc0 - os), 0);
      chk("mid rst idle", busy0, 1'b0);
      vs = vc1; ps = pc1;
      send(1, 8'h07, 0, 1'b1, 0);
      chk("perr pulse", pc1 - ps, 1);
      chk("perr valid", vc1 - vs, 0);
      vs = vc1;
      send(1, 8'h07, 1, 1'b1, 0);
      chk("par ok valid", vc1 - vs, 1);
      chk("par ok data", dout1, 8'hF8);
      chk("par ok raw", raw1, 8'h07);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_lfsr_rx.md
Name: uart_lfsr_rx

Overview:
Parametrised UART receiver with an integrated LFSR stream-cipher decrypt stage. It is the successor to the board-level fixed 8N1 receive path. It adds:
- configurable data width, parity and stop bits
- mid-bit sampling with start-glitch rejection
- error reporting
- a valid/ready output handshake

It sits between the async RX pin and the board logic (LED/seven-segment display, TX echo path).

Parameters:
CLKS_PER_BIT, 5208, M_CLOCK cycles per bit (50 MHz / 9600 baud); minimum 4
DATA_W, 8, data bits per frame (5..8), LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
LFSR_W, 8, keystream register width; must be >= DATA_W
LFSR_TAPS, 8'h1D, Galois feedback mask (x^8+x^4+x^3+x^2+1)
LFSR_SEED, 8'hFF, reset/default seed; must be non-zero

Ports:
M_CLOCK  in  1  system clock
M_RESET_N  in  1  async active-low reset; one clock; reset is asynchronous and active-low
rx_in  in  1  async serial line, idle high
seed_load  in  1  load seed_value into LFSR this cycle
seed_value  in  LFSR_W  new seed; 0 is replaced by all-ones
decrypt_en  in  1  1 = data_out is ciphertext ^ key; 0 = data_out = raw
data_out  out  DATA_W  received (decrypted) word
raw_out  out  DATA_W  received ciphertext, same frame as data_out
data_valid  out  1  word available; held until data_ready
data_ready  in  1  consumer accepts word when valid && ready
parity_err  out  1  one-cycle pulse, frame discarded
frame_err  out  1  one-cycle pulse, stop bit low, frame discarded
overrun  out  1  one-cycle pulse, unconsumed word overwritten
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - rx synchroniser flops = 1; FSM = IDLE; LFSR = LFSR_SEED.
  - data_out, raw_out = 0; data_valid, parity_err, frame_err, overrun, busy = 0.
  - Reset mid-frame abandons the frame with no pulses.
- Input synchroniser: 2 flops on rx_in; all logic uses rx_s (synchronised rx_in).
- FSM IDLE: on rx_s == 0, load bit counter with CLKS_PER_BIT/2 - 1 and go to START.
- FSM START: at counter expiry, sample rx_s.
  - 1: glitch, return to IDLE with no pulse.
  - 0: go to DATA, counter = CLKS_PER_BIT - 1, bit index = 0.
- FSM DATA: sample once per CLKS_PER_BIT at mid-bit and shift into the shift register LSB first. After DATA_W bits, go to PARITY if PARITY_MODE != 0, else STOP.
- FSM PARITY: sample the parity bit. Even mode: XOR of data bits and parity bit must be 0. Odd mode: must be 1. The mismatch is latched internally.
- FSM STOP: sample STOP_BITS times.
  - Any low sample: frame_err pulse; go to WAIT_IDLE.
  - Otherwise, at the final stop sample (cycle T):
    - parity mismatch: parity_err pulse at T+1; LFSR not advanced.
    - else accept: at T+1, raw_out = shift register, data_out = raw ^ key (key = LFSR[DATA_W-1:0] before advance), data_valid = 1, LFSR advances one step.
  - Return to IDLE.
- FSM WAIT_IDLE: remain until rx_s == 1 (break condition), then IDLE.
- LFSR step: next = {lfsr[LFSR_W-2:0], 1'b0} ^ (lfsr[LFSR_W-1] ? LFSR_TAPS : 0). The LFSR advances only on accepted frames; error frames keep the keystream aligned with the sender.
- seed_load: takes effect the next cycle in any state.
  - Same cycle as an accept: the frame uses the old key, and the seed load wins over the advance.
- Handshake: data_valid drops the cycle after valid && data_ready.
  - Accept while valid && !ready: overwrite outputs, data_valid stays 1, overrun pulses.
  - Accept in the same cycle as valid && ready: the new word is loaded, valid stays 1, no overrun.
- Latency: data_valid rises 1 cycle after the final stop-bit mid-sample, i.e. about (1 + DATA_W + parity + STOP_BITS - 0.5) * CLKS_PER_BIT + 3 cycles after the start edge at the pin.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE), PARITY_NONE/EVEN/ODD constants, default baud constant 5208.
- Sub-module lfsr_keystream: params LFSR_W, LFSR_TAPS, LFSR_SEED; ports M_CLOCK, M_RESET_N, load, load_value, advance, state. Reused by the matching transmitter.

Test Plan (CLKS_PER_BIT = 16, 8N1, seed 0xFF, decrypt_en = 1, data_ready = 1 unless stated):
- Frame ciphertext 0xA5 -> raw_out 0xA5, data_out 0x5A, one data_valid cycle; LFSR becomes 0xE3. Next frame 0xE3 -> data_out 0x00.
- Start-bit low pulse of 5 cycles -> no data_valid, no error pulse, busy returns to 0, LFSR unchanged at 0xFF.
- Frame 0x3C with stop bit driven low -> frame_err pulse, no data_valid. busy stays 1 until line high; next good frame 0xA5 -> data_out 0x5A (LFSR not advanced).
- PARITY_MODE = 1, frame 0x07 with parity bit 0 -> parity_err pulse, no data_valid. Same frame with parity 1 -> data_out 0xF8.
- data_ready = 0, two frames 0xA5 then 0xE3 -> overrun pulse on second; data_out 0x00, raw_out 0xE3, data_valid still 1.
- seed_load with seed_value 0x00 at the accept cycle of frame 0xA5 -> data_out 0x5A, LFSR = 0xFF afterwards. M_RESET_N asserted mid-DATA -> all outputs 0, no pulses.
